search_arbiter: RTL and testbench
=================================

SEARCH_ARBITER -- requirements
Module: search_arbiter

Interface
REQ-001 Parameter NUMBER_SIZE, default 32: width of each search target.
REQ-002 Parameter INDEX_SIZE, default 5: width of the returned index.
REQ-003 Parameter NUM_REQ, default 4: number of requesters sharing one binary_search engine.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles, used only when SEARCH_ARB_TIMEOUT_EN is defined.
REQ-005 Port clk  input  1: single clock; all logic on its rising edge.
REQ-006 Port rst  input  1: reset, synchronous, active-high.
REQ-007 Port req  input  NUM_REQ: per-requester level request.
REQ-008 Port target_in  input  NUM_REQ*NUMBER_SIZE: requester i target in slice [i*NUMBER_SIZE +: NUMBER_SIZE].
REQ-009 Port gnt  output  NUM_REQ: one-hot completion pulse to the served requester.
REQ-010 Port resp_valid  output  1: result valid pulse, coincident with gnt.
REQ-011 Port resp_id  output  $clog2(NUM_REQ): index of the served requester.
REQ-012 Port resp_index  output  INDEX_SIZE: search result.
REQ-013 Port resp_err  output  1: timeout flag; the port is present in both builds.
REQ-014 Port busy  output  1: high whenever the state is not IDLE.
REQ-015 Port eng_start  output  1: start pulse to the engine.
REQ-016 Port eng_target  output  NUMBER_SIZE: target to the engine, held stable from ISSUE through WAIT.
REQ-017 Port eng_out  input  INDEX_SIZE: engine result.
REQ-018 Port eng_done  input  1: one-cycle engine completion strobe; eng_out is valid in that cycle.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-020 In IDLE with any req bit high:
- winner = first i with req[i]=1, scanning upward from ptr and wrapping;
- latch winner into resp_id and its target into eng_target;
- go to ISSUE.
REQ-021 In ISSUE: eng_start=1 for exactly one cycle, then go to WAIT.
REQ-022 In WAIT, on eng_done=1: latch eng_out into resp_index, clear resp_err, go to RESP.
REQ-023 In RESP, for exactly one cycle: resp_valid=1 and gnt[resp_id]=1; ptr <= (resp_id+1) mod NUM_REQ; go to IDLE.
REQ-024 Latency from the IDLE sampling edge to resp_valid is 3 cycles plus the engine latency; back-to-back throughput is one search per (4 + engine latency) cycles.
REQ-025 req is sampled only in IDLE:
- deasserting req mid-search does not cancel the search; the response is still issued;
- new req edges outside IDLE are ignored until the FSM returns to IDLE.
REQ-026 eng_done outside WAIT is ignored.
REQ-027 resp_id, resp_index and resp_err hold their values after RESP until the next capture.
REQ-028 A requester still holding req after its gnt is served again only after every other pending requester has been served (round-robin fairness).
REQ-029 NUM_REQ=1 is legal; ptr is then constant 0.

Reset
REQ-030 When rst=1 at a clock edge, in any state:
- state <= IDLE; ptr <= 0;
- gnt, resp_valid, eng_start, resp_err <= 0;
- resp_id, resp_index, eng_target <= 0.
REQ-031 A search in flight when rst is asserted is abandoned with no response; an eng_done arriving later is ignored.

Configuration
REQ-032 With macro SEARCH_ARB_TIMEOUT_EN defined:
- a counter clears on entry to WAIT and increments every WAIT cycle;
- if it reaches TIMEOUT_CYCLES before eng_done, go to RESP with resp_err=1 and resp_index all ones.
REQ-033 With SEARCH_ARB_TIMEOUT_EN undefined: no counter exists, WAIT lasts until eng_done, and resp_err is tied to 0.

Verification
REQ-034 Single request: req=4'b0001, target 15, engine model returns 7 after 6 cycles -> eng_start pulses once with eng_target=15; resp_valid, gnt=4'b0001, resp_id=0, resp_index=7 appear 9 cycles after sampling.
REQ-035 Round-robin: req=4'b1111 held, distinct targets -> grant order 0,1,2,3,0; no requester is served twice in a row.
REQ-036 Drop mid-search: req[2] pulsed for 1 cycle only -> full response with gnt=4'b0100 is still issued.
REQ-037 Reset in WAIT: rst for 1 cycle, then eng_done pulsed -> no resp_valid; all outputs 0; busy=0.
REQ-038 Timeout build, engine never asserts eng_done, TIMEOUT_CYCLES=64 -> resp_valid with resp_err=1 and resp_index=5'h1F after 64 WAIT cycles; non-timeout build stays busy indefinitely.
REQ-039 Spurious eng_done in IDLE or ISSUE -> no state change and no response.

Source files
------------

// File: rtl/search_arbiter.sv
// search_arbiter: round-robin front end that lets NUM_REQ requesters share a
// single binary_search engine, one search at a time.
// Optional feature: define SEARCH_ARB_TIMEOUT_EN to add a WAIT-state watchdog
// that returns resp_err=1 and an all-ones index after TIMEOUT_CYCLES.
// Without the macro there is no watchdog and resp_err is constant 0.
module search_arbiter #(
  parameter int NUMBER_SIZE    = 32,
  parameter int INDEX_SIZE     = 5,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  // The id needs at least one bit, so a single-requester build still has a port.
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*NUMBER_SIZE-1:0] target_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           resp_valid,
  output logic [ID_W-1:0]                resp_id,
  output logic [INDEX_SIZE-1:0]          resp_index,
  output logic                           resp_err,
  output logic                           busy,
  output logic                           eng_start,
  output logic [NUMBER_SIZE-1:0]         eng_target,
  input  logic [INDEX_SIZE-1:0]          eng_out,
  input  logic                           eng_done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic [NUM_REQ-1:0] gnt_onehot;

`ifdef SEARCH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // First requester at or after ptr, wrapping around; ptr itself if none asks.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] w;
    logic [ID_W:0]   sum;
    w = p;
    // Scan from the farthest candidate back toward ptr so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, p} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
      if (r[sum[ID_W-1:0]]) w = sum[ID_W-1:0];
    end
    return w;
  endfunction

  // Round-robin choice among the currently asserted requests.
  always_comb begin
    winner = pick_winner(req, ptr);
  end

  // Completion pulse pattern for the requester being served.
  always_comb begin
    gnt_onehot          = '0;
    gnt_onehot[resp_id] = 1'b1;
  end

  assign busy = (state != IDLE);

`ifndef SEARCH_ARB_TIMEOUT_EN
  assign resp_err = 1'b0;
`endif

  // Main arbitration FSM; every output except busy/resp_err is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      resp_valid <= 1'b0;
      eng_start  <= 1'b0;
      resp_id    <= '0;
      resp_index <= '0;
      eng_target <= '0;
`ifdef SEARCH_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      gnt        <= '0;
      resp_valid <= 1'b0;
      eng_start  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            resp_id    <= winner;
            eng_target <= target_in[winner*NUMBER_SIZE +: NUMBER_SIZE];
            eng_start  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SEARCH_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            resp_index <= eng_out;
            resp_valid <= 1'b1;
            gnt        <= gnt_onehot;
`ifdef SEARCH_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef SEARCH_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            resp_index <= '1;
            resp_valid <= 1'b1;
            gnt        <= gnt_onehot;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_id == ID_W'(NUM_REQ - 1)) ptr <= '0;
          else                               ptr <= resp_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_search_arbiter.sv
// tb_search_arbiter: scoreboard bench for search_arbiter with a behavioural
// engine that answers target[5:1] a programmable number of cycles after start.
// Build with SEARCH_ARB_TIMEOUT_EN defined to exercise the watchdog response.
module tb_search_arbiter;

  localparam int NS = 32;
  localparam int IS = 5;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [IW-1:0] id;
    logic [IS-1:0] index;
    logic          err;
    int            exp_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*NS-1:0] target_in;
  logic [NR-1:0]    gnt;
  logic             resp_valid;
  logic [IW-1:0]    resp_id;
  logic [IS-1:0]    resp_index;
  logic             resp_err;
  logic             busy;
  logic             eng_start;
  logic [NS-1:0]    eng_target;
  logic [IS-1:0]    eng_out = '0;
  logic             eng_done;
  logic             eng_done_model = 1'b0;
  logic             eng_done_spur = 1'b0;

  logic [NS-1:0] tgt [NR];
  exp_t          sbq[$];
  int            eng_lat = 3;
  bit            eng_mute = 1'b0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fails = 0;

  assign eng_done = eng_done_model | eng_done_spur;

  search_arbiter #(
    .NUMBER_SIZE(NS), .INDEX_SIZE(IS), .NUM_REQ(NR), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .target_in(target_in),
    .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_index(resp_index), .resp_err(resp_err), .busy(busy),
    .eng_start(eng_start), .eng_target(eng_target),
    .eng_out(eng_out), .eng_done(eng_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NR; i++) target_in[i*NS +: NS] = tgt[i];
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse req for one cycle, queue the expected response and check the ISSUE cycle.
  task automatic applyStimulus(input logic [NR-1:0] r, input int lat, input int win,
                               input bit spur, input bit expect_resp,
                               input logic err, input logic [IS-1:0] idx,
                               input int lat_total);
    exp_t e;
    @(negedge clk);
    eng_lat = lat;
    req     = r;
    if (expect_resp) begin
      e.gnt     = NR'(1) << win;
      e.id      = IW'(win);
      e.index   = idx;
      e.err     = err;
      e.exp_cyc = cyc + lat_total;
      sbq.push_back(e);
    end
    @(negedge clk);
    req           = '0;
    eng_done_spur = spur;
    checkOutput("issue_start", eng_start, 1);
    checkOutput("issue_target", eng_target, tgt[win]);
    @(negedge clk);
    eng_done_spur = 1'b0;
  endtask

  task automatic waitResponses(input int n, input int budget);
    int seen = 0;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (resp_valid) seen++;
      budget--;
    end
    checkOutput("resp_count", seen, n);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_gnt"}, gnt, 0);
    checkOutput({tag, "_valid"}, resp_valid, 0);
    checkOutput({tag, "_id"}, resp_id, 0);
    checkOutput({tag, "_index"}, resp_index, 0);
    checkOutput({tag, "_err"}, resp_err, 0);
    checkOutput({tag, "_start"}, eng_start, 0);
    checkOutput({tag, "_target"}, eng_target, 0);
  endtask

  // Behavioural engine: latches the target at start, answers target[5:1] later.
  initial begin
    logic [NS-1:0] cap;
    forever begin
      @(negedge clk);
      if (eng_start && !eng_mute) begin
        cap = eng_target;
        @(negedge clk);
        checkOutput("eng_start_width", eng_start, 0);
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_out        = cap[5:1];
        eng_done_model = 1'b1;
        checkOutput("eng_target_hold", eng_target, cap);
        @(posedge clk);
        #1 eng_done_model = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_resp", {31'd0, resp_valid}, 0);
      end else begin
        e = sbq.pop_front();
        checkOutput("resp_gnt", gnt, e.gnt);
        checkOutput("resp_id", resp_id, e.id);
        checkOutput("resp_index", resp_index, e.index);
        checkOutput("resp_err", resp_err, e.err);
        if (e.exp_cyc >= 0) checkOutput("resp_latency", cyc, e.exp_cyc);
      end
    end else if (gnt != '0) begin
      checkOutput("gnt_without_valid", gnt, 0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int seen;
    int budget;
    tgt[0] = 32'd15;
    tgt[1] = 32'd20;
    tgt[2] = 32'd30;
    tgt[3] = 32'd40;

    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;

    $display("[TB] single request, engine latency 6");
    applyStimulus(4'b0001, 6, 0, 1'b0, 1'b1, 1'b0, 5'd7, 9);
    waitResponses(1, 40);
    repeat (3) @(negedge clk);
    checkOutput("hold_id", resp_id, 0);
    checkOutput("hold_index", resp_index, 7);
    checkOutput("hold_busy", busy, 0);

    $display("[TB] spurious eng_done in IDLE");
    @(negedge clk);
    eng_done_spur = 1'b1;
    @(negedge clk);
    eng_done_spur = 1'b0;
    checkOutput("spur_idle_busy", busy, 0);
    repeat (3) @(negedge clk);

    $display("[TB] spurious eng_done in ISSUE, ptr now 1");
    applyStimulus(4'b0010, 3, 1, 1'b1, 1'b1, 1'b0, 5'd10, 6);
    waitResponses(1, 30);

    $display("[TB] round robin with all requests held");
    doReset();
    eng_lat = 2;
    sbq.push_back('{4'b0001, 2'd0, 5'd7,  1'b0, -1});
    sbq.push_back('{4'b0010, 2'd1, 5'd10, 1'b0, -1});
    sbq.push_back('{4'b0100, 2'd2, 5'd15, 1'b0, -1});
    sbq.push_back('{4'b1000, 2'd3, 5'd20, 1'b0, -1});
    sbq.push_back('{4'b0001, 2'd0, 5'd7,  1'b0, -1});
    @(negedge clk);
    req    = 4'b1111;
    seen   = 0;
    budget = 100;
    while (seen < 5 && budget > 0) begin
      @(negedge clk);
      if (resp_valid) seen++;
      budget--;
    end
    req = '0;
    checkOutput("rr_count", seen, 5);
    repeat (12) @(negedge clk);
    checkOutput("rr_queue_empty", sbq.size(), 0);

    $display("[TB] request dropped after one cycle");
    doReset();
    applyStimulus(4'b0100, 4, 2, 1'b0, 1'b1, 1'b0, 5'd15, 7);
    waitResponses(1, 30);

    $display("[TB] reset while waiting on the engine");
    eng_mute = 1'b1;
    applyStimulus(4'b1000, 0, 3, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    repeat (2) @(negedge clk);
    checkOutput("wait_busy", busy, 1);
    doReset();
    eng_done_spur = 1'b1;
    @(negedge clk);
    eng_done_spur = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleZero("after_rst");

`ifdef SEARCH_ARB_TIMEOUT_EN
    $display("[TB] engine never answers, watchdog build");
    applyStimulus(4'b0001, 0, 0, 1'b0, 1'b1, 1'b1, 5'h1F, 66);
    waitResponses(1, 100);
    repeat (2) @(negedge clk);
    checkOutput("timeout_hold_err", resp_err, 1);
`else
    $display("[TB] engine never answers, no watchdog");
    applyStimulus(4'b0001, 0, 0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    repeat (100) @(negedge clk);
    checkOutput("stuck_busy", busy, 1);
    checkOutput("stuck_err", resp_err, 0);
    doReset();
    @(negedge clk);
    checkOutput("stuck_reset_busy", busy, 0);
`endif
    eng_mute = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
